symf_outfifo: RTL and testbench

//  Output stage for the slow symmetric FIR filter. It accepts each full-width

---
 rtl/symf_outfifo.sv | 142 ++++++++++++++
 tb/tb_symf_outfifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/symf_outfifo.sv
// Output stage of the slow symmetric FIR: convergent rounding, saturation to OW bits,
// and a first-word-fall-through FIFO with a valid/ready read port and sticky status flags.
module symf_outfifo #(
  parameter int unsigned IW     = 35,
  parameter int unsigned OW     = 16,
  parameter int unsigned DROP   = 12,
  parameter int unsigned LGFIFO = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce,
  input  logic [IW-1:0]     i_sample,
  input  logic              i_clear,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OW-1:0]     o_data,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_overflow,
  output logic              o_dropped
);

  localparam int unsigned SW    = IW + 1;
  localparam int unsigned RW    = IW + 1 - DROP;
  localparam int unsigned HW    = RW - OW + 1;
  localparam int unsigned FW    = LGFIFO + 1;
  localparam int unsigned DEPTH = 1 << LGFIFO;
  localparam logic [SW-1:0] BIAS    = SW'((1 << (DROP - 1)) - 1);
  localparam logic [OW-1:0] SAT_MAX = {1'b0, {(OW - 1){1'b1}}};
  localparam logic [OW-1:0] SAT_MIN = {1'b1, {(OW - 1){1'b0}}};

  logic              s1_valid;
  logic [RW-1:0]     s1_data;
  logic              s2_valid;
  logic [OW-1:0]     s2_data;
  logic              w_valid;
  logic [OW-1:0]     w_data;
  logic [OW-1:0]     mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr;
  logic [LGFIFO-1:0] rd_ptr;

  logic [SW-1:0]     sum_c;
  logic [HW-1:0]     hi_c;
  logic              pos_sat_c;
  logic              neg_sat_c;
  logic [OW-1:0]     sat_data_c;
  logic              rd_c;
  logic              full_c;
  logic              wr_c;
  logic              drop_c;
  logic [LGFIFO-1:0] next_rd_c;
  logic [FW-1:0]     next_fill_c;
  logic [OW-1:0]     head_c;

  // Round half to even: bias is just under one half, plus one when the kept LSB is odd.
  always_comb begin
    sum_c = {i_sample[IW-1], i_sample} + BIAS + SW'(i_sample[DROP]);
  end

  // Out of range whenever the bits above the output sign disagree with it.
  always_comb begin
    hi_c      = s1_data[RW-1:OW-1];
    pos_sat_c = ~s1_data[RW-1] & (|hi_c);
    neg_sat_c = s1_data[RW-1] & ~(&hi_c);
    if (pos_sat_c) begin
      sat_data_c = SAT_MAX;
    end else if (neg_sat_c) begin
      sat_data_c = SAT_MIN;
    end else begin
      sat_data_c = s1_data[OW-1:0];
    end
  end

  // FIFO control; the head word for the next cycle is precomputed so o_data stays registered.
  always_comb begin
    rd_c        = o_valid & i_ready;
    full_c      = (o_fill == FW'(DEPTH));
    wr_c        = w_valid & (~full_c | rd_c);
    drop_c      = w_valid & full_c & ~rd_c;
    next_rd_c   = rd_ptr + LGFIFO'(rd_c);
    next_fill_c = o_fill;
    head_c      = '0;
    case ({wr_c, rd_c})
      2'b10:   next_fill_c = o_fill + FW'(1);
      2'b01:   next_fill_c = o_fill - FW'(1);
      default: next_fill_c = o_fill;
    endcase
    if (next_fill_c == '0) begin
      head_c = '0;
    end else if ((o_fill == '0) || (rd_c && (o_fill == FW'(1)))) begin
      head_c = w_data;
    end else begin
      head_c = mem[next_rd_c];
    end
  end

  // Rounding, saturation and write-staging pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      w_valid  <= 1'b0;
      w_data   <= '0;
    end else begin
      s1_valid <= i_ce;
      s1_data  <= RW'(sum_c >> DROP);
      s2_valid <= s1_valid;
      s2_data  <= sat_data_c;
      w_valid  <= s2_valid;
      w_data   <= s2_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_c) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_fill     <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
      o_dropped  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + LGFIFO'(wr_c);
      rd_ptr     <= next_rd_c;
      o_fill     <= next_fill_c;
      o_valid    <= (next_fill_c != '0);
      o_data     <= head_c;
      // A new event on the clearing edge keeps the flag set.
      o_overflow <= (s1_valid & (pos_sat_c | neg_sat_c)) | (o_overflow & ~i_clear);
      o_dropped  <= drop_c | (o_dropped & ~i_clear);
    end
  end

endmodule

// File: tb/tb_symf_outfifo.sv
// Directed bench for symf_outfifo: rounding, saturation, latency, overflow drop,
// full-with-read and mid-stream reset, checked by immediate assertions.
module tb_symf_outfifo;

  logic               clk;
  logic               reset;
  logic               ce;
  logic [34:0]        sample;
  logic               clear;
  logic               valid;
  logic               ready;
  logic [15:0]        data;
  logic [3:0]         fill;
  logic               overflow;
  logic               dropped;

  int checks;
  int errors;

  symf_outfifo #(.IW(35), .OW(16), .DROP(12), .LGFIFO(3)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_ce       (ce),
    .i_sample   (sample),
    .i_clear    (clear),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_data     (data),
    .o_fill     (fill),
    .o_overflow (overflow),
    .o_dropped  (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [34:0] v);
    ce     = 1'b1;
    sample = v;
    tick();
    ce     = 1'b0;
    sample = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [34:0] rnd_in [5];
  logic [15:0] rnd_out [5];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    ce     = 1'b0;
    sample = '0;
    clear  = 1'b0;
    ready  = 1'b0;
    rnd_in[0] = 35'h800;   rnd_out[0] = 16'd0;
    rnd_in[1] = 35'h1800;  rnd_out[1] = 16'd2;
    rnd_in[2] = 35'h2800;  rnd_out[2] = 16'd2;
    rnd_in[3] = -35'sh800; rnd_out[3] = 16'd0;
    rnd_in[4] = 35'h801;   rnd_out[4] = 16'd1;

    tick();
    tick();
    reset = 1'b0;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_fill", 32'(fill), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    check("reset_flags", 32'({overflow, dropped}), 32'd0);

    // Rounding half to even
    for (int i = 0; i < 5; i++) push(rnd_in[i]);
    tick(); tick(); tick();
    check("rnd_fill", 32'(fill), 32'd5);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rnd_valid_%0d", i), 32'(valid), 32'd1);
      check($sformatf("rnd_data_%0d", i), 32'(data), 32'(rnd_out[i]));
      tick();
    end
    ready = 1'b0;
    check("rnd_empty", 32'(valid), 32'd0);
    check("rnd_overflow", 32'(overflow), 32'd0);

    // Saturation both ways, then clear
    push(35'd134217728);
    push(-35'sd134221824);
    tick(); tick(); tick();
    check("sat_overflow", 32'(overflow), 32'd1);
    check("sat_fill", 32'(fill), 32'd2);
    check("sat_pos", 32'(data), 32'h7FFF);
    ready = 1'b1;
    tick();
    check("sat_neg", 32'(data), 32'h8000);
    tick();
    ready = 1'b0;
    check("sat_empty", 32'(valid), 32'd0);
    pulse_clear();
    check("sat_cleared", 32'(overflow), 32'd0);

    // Latency: visible exactly three edges after the sampling edge
    ready = 1'b1;
    push(35'd5 << 12);
    check("lat_n0", 32'(valid), 32'd0);
    tick();
    check("lat_n1", 32'(valid), 32'd0);
    tick();
    check("lat_n2", 32'(valid), 32'd0);
    tick();
    check("lat_n3_valid", 32'(valid), 32'd1);
    check("lat_n3_data", 32'(data), 32'd5);
    check("lat_n3_fill", 32'(fill), 32'd1);
    tick();
    check("lat_n4_valid", 32'(valid), 32'd0);
    check("lat_n4_fill", 32'(fill), 32'd0);
    ready = 1'b0;

    // Overflow: ninth sample dropped
    for (int k = 1; k <= 9; k++) push(35'(k) << 12);
    tick(); tick(); tick();
    check("ovf_fill", 32'(fill), 32'd8);
    check("ovf_dropped", 32'(dropped), 32'd1);
    check("ovf_overflow", 32'(overflow), 32'd0);
    ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ovf_data_%0d", k), 32'(data), 32'(k));
      tick();
    end
    ready = 1'b0;
    check("ovf_empty", 32'(valid), 32'd0);
    check("ovf_fill0", 32'(fill), 32'd0);
    pulse_clear();
    check("ovf_cleared", 32'(dropped), 32'd0);

    // Full with simultaneous read: write accepted
    for (int k = 1; k <= 8; k++) push(35'(k) << 12);
    tick(); tick(); tick();
    check("fwr_fill_pre", 32'(fill), 32'd8);
    push(35'd10 << 12);
    tick();
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("fwr_fill", 32'(fill), 32'd8);
    check("fwr_dropped", 32'(dropped), 32'd0);
    check("fwr_head", 32'(data), 32'd2);
    ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      check($sformatf("fwr_data_%0d", k), 32'(data), 32'(k));
      tick();
    end
    check("fwr_last", 32'(data), 32'd10);
    tick();
    ready = 1'b0;
    check("fwr_empty", 32'(valid), 32'd0);

    // Reset mid-stream: three buffered, two in flight (last one saturates)
    for (int k = 1; k <= 4; k++) push(35'(k) << 12);
    push(-35'sd134221824);
    tick();
    check("rst_pre_fill", 32'(fill), 32'd3);
    check("rst_pre_overflow", 32'(overflow), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_flags", 32'({overflow, dropped}), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("rst_no_stale_valid", 32'(valid), 32'd0);
    check("rst_no_stale_fill", 32'(fill), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
